// File: rtl/rotseq_pkg.sv
// Shared types and constants for the rotate command sequencer.
// Holds the FSM state encoding and the fixed rotator widths.
package rotseq_pkg;

    localparam int ROT_W  = 3;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rotation_right_shifter.sv
// Combinational 8-bit right rotator built from fixed 1/2/4-bit stages.
module rotation_right_shifter
    import rotseq_pkg::*;
(
    input  logic [DATA_W-1:0] i_num,
    input  logic [ROT_W-1:0]  i_num_bit_rotation,
    output logic [DATA_W-1:0] o_result
);

    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;

    assign s1 = i_num_bit_rotation[0] ?
                {i_num[0], i_num[7:1]} : i_num;
    assign s2 = i_num_bit_rotation[1] ?
                {s1[1:0], s1[7:2]} : s1;
    assign o_result = i_num_bit_rotation[2] ?
                      {s2[3:0], s2[7:4]} : s2;

endmodule

// File: rtl/rotate_cmd_sequencer.sv
// Repeated-rotation command front-end for the 8-bit rotator.
// Define ROTSEQ_LEFT_EN to add i_dir (left rotation support).
module rotate_cmd_sequencer
    import rotseq_pkg::*;
#(
    parameter int N     = DATA_W,
    parameter int W_REP = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_num,
    input  logic [ROT_W-1:0] i_num_bit_rotation,
    input  logic [W_REP-1:0] i_repeat,
`ifdef ROTSEQ_LEFT_EN
    input  logic             i_dir,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_result,
    output logic             o_busy
);

    state_t           state_q;
    state_t           state_d;
    logic [N-1:0]     data_q;
    logic [ROT_W-1:0] amt_q;
    logic [W_REP-1:0] cnt_q;
    logic [ROT_W-1:0] eff_amt;
    logic [N-1:0]     rot_data;
    logic             accept;

    assign accept = i_valid && (state_q == ST_IDLE);

`ifdef ROTSEQ_LEFT_EN
    logic dir_q;

    // A left rotation by a is a right rotation by (8-a) mod 8.
    assign eff_amt = dir_q ? (ROT_W'(0) - amt_q) : amt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            dir_q <= 1'b0;
        end else if (accept) begin
            dir_q <= i_dir;
        end
    end
`else
    assign eff_amt = amt_q;
`endif

    rotation_right_shifter u_rot (
        .i_num              (data_q),
        .i_num_bit_rotation (eff_amt),
        .o_result           (rot_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= i_num;
                amt_q  <= i_num_bit_rotation;
                cnt_q  <= i_repeat;
            end else if (state_q == ST_RUN) begin
                data_q <= rot_data;
                cnt_q  <= cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_d = (i_repeat != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (cnt_q == W_REP'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_busy  = 1'b1;
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Held unchanged through DONE, so the result is stable under backpressure.
    assign o_result = data_q;

endmodule
